// File: rtl/multicycle_control_if.sv
// Control-to-datapath/memory bundle for the multi-cycle controller.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                pc_write;
  logic                jump;
  logic                branch;
  logic                beq;
  logic                reg_dst;
  logic                alu_src;
  logic                mem_to_reg;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                instr_done;
  logic                illegal_op;
  logic                bus_err;
  logic                halted;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_read, mem_write, ir_write, pc_write, jump, branch, beq,
           reg_dst, alu_src, mem_to_reg, reg_write, alu_op, instr_done, illegal_op,
           bus_err, halted
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_read, mem_write, ir_write, pc_write, jump, branch, beq,
           reg_dst, alu_src, mem_to_reg, reg_write, alu_op, instr_done, illegal_op,
           bus_err, halted
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB); CTRL_PERF_CNT_EN adds retired/stall counters.
// Latency at zero wait states: j/beq/bne 3, add/addi/sw 4, lw 5 cycles; illegal/halt retire in DECODE.
// Backpressure: mem_req held until mem_ready; MEM_TIMEOUT wait cycles set sticky bus_err and halt.
module multicycle_control #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master ctl
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]          retired_cnt,
  output logic [15:0]          stall_cnt
`endif
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          opcode_q;
  logic [7:0]          wait_cnt_q;
  logic                bus_err_q;
  logic                bus_err_set;
  logic                timeout;
  logic [OPCODE_W-1:0] op_full;
  logic [3:0]          op_lo;
  logic                op_legal;

  assign op_full  = ctl.opcode;
  assign op_lo    = op_full[3:0];
  assign op_legal = ((op_full >> 4) == '0) && ((op_lo <= OP_J) || (op_lo == OP_HALT));
  // A ready in the final wait cycle still wins over the timeout.
  assign timeout  = (wait_cnt_q == TIMEOUT) && !ctl.mem_ready;

  always_comb begin
    ctl.mem_req    = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.ir_write   = 1'b0;
    ctl.pc_write   = 1'b0;
    ctl.jump       = 1'b0;
    ctl.branch     = 1'b0;
    ctl.beq        = 1'b0;
    ctl.reg_dst    = 1'b0;
    ctl.alu_src    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.alu_op     = '0;
    ctl.instr_done = 1'b0;
    ctl.illegal_op = 1'b0;
    ctl.bus_err    = bus_err_q & ~rst;
    ctl.halted     = 1'b0;
    state_d        = state_q;
    bus_err_set    = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          if (timeout) begin
            bus_err_set = 1'b1;
            state_d     = S_HALT;
          end else begin
            ctl.mem_req  = 1'b1;
            ctl.mem_read = 1'b1;
            if (ctl.mem_ready) begin
              ctl.ir_write = 1'b1;
              ctl.pc_write = 1'b1;
              state_d      = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (!op_legal) begin
            ctl.illegal_op = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end else if (op_lo == OP_HALT) begin
            ctl.instr_done = 1'b1;
            state_d        = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_ADD: begin
              ctl.reg_dst = 1'b1;
              state_d     = S_WB;
            end
            OP_ADDI: begin
              ctl.alu_src = 1'b1;
              state_d     = S_WB;
            end
            OP_LW, OP_SW: begin
              ctl.alu_src = 1'b1;
              state_d     = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              ctl.alu_op     = ALU_OP_W'(1);
              ctl.branch     = 1'b1;
              ctl.beq        = (opcode_q == OP_BEQ);
              ctl.instr_done = 1'b1;
              state_d        = S_FETCH;
            end
            OP_J: begin
              ctl.jump       = 1'b1;
              ctl.pc_write   = 1'b1;
              ctl.instr_done = 1'b1;
              state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (timeout) begin
            bus_err_set = 1'b1;
            state_d     = S_HALT;
          end else begin
            ctl.mem_req   = 1'b1;
            ctl.mem_read  = (opcode_q == OP_LW);
            ctl.mem_write = (opcode_q == OP_SW);
            if (ctl.mem_ready) begin
              if (opcode_q == OP_LW) begin
                state_d = S_WB;
              end else begin
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
              end
            end
          end
        end
        S_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = (opcode_q == OP_ADD);
          ctl.mem_to_reg = (opcode_q == OP_LW);
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
        S_HALT:  ctl.halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= op_lo;
      end
      if (bus_err_set) begin
        bus_err_q <= 1'b1;
      end
      // Each new access starts its own wait budget.
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
        wait_cnt_q <= '0;
      end else if (ctl.mem_req && !ctl.mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (ctl.instr_done) begin
        retired_q <= retired_q + 16'd1;
      end
      if (ctl.mem_req && !ctl.mem_ready) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign retired_cnt = rst ? 16'd0 : retired_q;
  assign stall_cnt   = rst ? 16'd0 : stall_q;
`endif
endmodule
